// File: rtl/alu_sequencer.sv
// alu_sequencer: instruction sequencer for the 8 x 12-bit register file / ALU
// datapath. It holds a small program, then fetches and decodes each word and
// drives the opcode and register-address fields to the datapath. After the
// opcode's execute latency it issues a one-cycle register write strobe.
// Instruction word layout: opcode[11:9], dest[8:6], src1[5:3], src2[2:0].
module alu_sequencer #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int LAT_ALU = 1,
  parameter int LAT_MUL = 3,
  parameter int LAT_FP  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [11:0]   load_data,
  input  logic          start,
  input  logic          halt_req,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] pc,
  output logic [2:0]    opcode,
  output logic [2:0]    addr1,
  output logic [2:0]    addr2,
  output logic [2:0]    addr3,
  output logic          alu_valid,
  output logic          reg_we,
  output logic [7:0]    retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [2:0]    OP_HALT = 3'b000;
  localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);

  // Execute latency per opcode; the HALT encoding never reaches EXEC.
  function automatic logic [7:0] op_latency(input logic [2:0] op);
    logic [7:0] lat;
    case (op)
      3'b001, 3'b010, 3'b111: lat = 8'(LAT_ALU);
      3'b011, 3'b100:         lat = 8'(LAT_MUL);
      3'b101, 3'b110:         lat = 8'(LAT_FP);
      default:                lat = 8'(LAT_ALU);
    endcase
    return lat;
  endfunction

  state_t        r_state;
  logic [11:0]   r_mem [DEPTH];
  logic [11:0]   r_ir;
  logic [7:0]    r_cnt;
  logic [AW-1:0] r_pc;
  logic [7:0]    r_retired;
  logic          r_busy;
  logic          r_done;
  logic [2:0]    r_opcode;
  logic [2:0]    r_addr1;
  logic [2:0]    r_addr2;
  logic [2:0]    r_addr3;
  logic          r_alu_valid;
  logic          r_reg_we;

  // Loads are only accepted while no program is running.
  logic w_load_ok;
  assign w_load_ok = load_en && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Program memory write port; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (rst_n && w_load_ok) begin
      r_mem[load_addr] <= load_data;
    end
  end

  // Sequencer FSM with all datapath-facing outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ir        <= 12'd0;
      r_cnt       <= 8'd0;
      r_pc        <= '0;
      r_retired   <= 8'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_opcode    <= 3'd0;
      r_addr1     <= 3'd0;
      r_addr2     <= 3'd0;
      r_addr3     <= 3'd0;
      r_alu_valid <= 1'b0;
      r_reg_we    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          // A simultaneous load wins over start.
          if (start && !load_en) begin
            r_pc      <= '0;
            r_retired <= 8'd0;
            r_done    <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_ir    <= r_mem[r_pc];
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          if (r_ir[11:9] == OP_HALT) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt       <= op_latency(r_ir[11:9]);
            r_opcode    <= r_ir[11:9];
            r_addr1     <= r_ir[8:6];
            r_addr2     <= r_ir[5:3];
            r_addr3     <= r_ir[2:0];
            r_alu_valid <= 1'b1;
            r_state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Counter loaded with LAT gives exactly LAT cycles of dwell.
          if (r_cnt <= 8'd1) begin
            r_cnt    <= 8'd0;
            r_reg_we <= 1'b1;
            r_state  <= S_WB;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_WB: begin
          r_reg_we    <= 1'b0;
          r_alu_valid <= 1'b0;
          r_opcode    <= 3'd0;
          r_addr1     <= 3'd0;
          r_addr2     <= 3'd0;
          r_addr3     <= 3'd0;
          if (r_retired != 8'hFF) begin
            r_retired <= r_retired + 8'd1;
          end
          // Stop on request or at the last word; pc never wraps.
          if (halt_req || (r_pc == PC_LAST)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_pc    <= r_pc + AW'(1);
            r_state <= S_FETCH;
          end
        end
        default: begin
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_alu_valid <= 1'b0;
          r_reg_we    <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pc        = r_pc;
  assign opcode    = r_opcode;
  assign addr1     = r_addr1;
  assign addr2     = r_addr2;
  assign addr3     = r_addr3;
  assign alu_valid = r_alu_valid;
  assign reg_we    = r_reg_we;
  assign retired   = r_retired;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Instruction sequencer for the 8-entry × 12-bit register file / ALU datapath (`ALUinterface_memory`).
- Holds a small program of 12-bit instructions: opcode[11:9], dest[8:6], src1[5:3], src2[2:0].
- Fetches and decodes each instruction, then drives opcode/address fields to the datapath.
- Waits out a per-opcode execute latency, then issues a one-cycle register write-enable. Replaces hand-sequenced instruction/clk stimulus.

Parameters:
- DEPTH, 16, number of program words; power of two, ≥2.
- AW, 4, program address width; log2(DEPTH).
- LAT_ALU, 1, execute cycles for ADD(001), SUB(010), CMP(111); ≥1.
- LAT_MUL, 3, execute cycles for MUL(011), IMUL(100); ≥1.
- LAT_FP, 4, execute cycles for FADD(101), FMUL(110); ≥1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active-low, sampled on rising clk.
- load_en  in  1  write load_data into program memory at load_addr.
- load_addr  in  AW  program write address.
- load_data  in  12  program word.
- start  in  1  begin execution at pc=0.
- halt_req  in  1  stop after the current instruction retires.
- busy  out  1  high in FETCH/DECODE/EXEC/WB.
- done  out  1  high in DONE state.
- pc  out  AW  address of the current instruction.
- opcode  out  3  to datapath; 000 when not executing.
- addr1  out  3  destination register to datapath.
- addr2  out  3  source 1 register to datapath.
- addr3  out  3  source 2 register to datapath.
- alu_valid  out  1  opcode/addr fields valid (EXEC and WB).
- reg_we  out  1  one-cycle register write strobe (WB).
- retired  out  8  count of retired instructions since start; saturates at 255.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; pc=0; IR=0; latency counter=0; retired=0.
  - All outputs 0.
  - Program memory is not cleared.
  - Reset mid-execution aborts with no further reg_we.
- States: IDLE, FETCH, DECODE, EXEC, WB, DONE.
- Loading:
  - load_en is accepted only in IDLE or DONE; ignored in any other state.
  - Write takes effect at the edge.
  - If load_en and start are both high in the same cycle, the load is performed and start is ignored.
- IDLE/DONE + start (no load_en): pc←0, retired←0, done←0, go to FETCH.
- FETCH (1 cycle): IR←mem[pc]; go to DECODE.
- DECODE (1 cycle):
  - If IR opcode=000 (HALT): go to DONE; retired unchanged.
  - Otherwise load counter with the latency for that opcode, drive opcode/addr1..3 from IR, set alu_valid=1, go to EXEC.
- EXEC:
  - Fields held stable; counter decrements each cycle.
  - When the counter reads 1, go to WB next cycle.
  - Dwell in EXEC is exactly LAT_x cycles.
- WB (1 cycle):
  - reg_we=1; fields still driven; retired increments (saturating).
  - If halt_req=1 or pc=DEPTH-1: go to DONE, pc unchanged.
  - Otherwise pc←pc+1 and go to FETCH. pc never wraps.
- Outside EXEC/WB: opcode, addr1..3, alu_valid and reg_we are all 0.
- halt_req:
  - Sampled only in WB; ignored elsewhere.
  - Has no effect on an instruction already in FETCH/DECODE/EXEC, which still completes and writes back.
- Per-instruction cycle cost: 3 + LAT. With defaults: ADD=4, MUL=6, FADD=7.
- DONE:
  - done=1 and busy=0, held until start.
  - pc holds the address of the last instruction (HALT or the final retired instruction).
- start asserted while busy is ignored.

Test Plan:
- Load mem[0]=001010000001 (ADD R2,R0,R1), mem[1]=000000000000; pulse start → opcode=001, addr1=2, addr2=0, addr3=1 for 2 cycles; reg_we high exactly 1 cycle, 3 cycles after FETCH; then done=1, retired=1, pc=1.
- Program ADD, MUL(011100000001), FADD(101111101110), HALT → reg_we pulses spaced 4, 6, 7 cycles apart; retired=3; total 4+6+7+2=19 cycles from start to done.
- Fill all 16 words with SUB(010011000001), no HALT → 16 reg_we pulses; done with pc=15, retired=16; no wrap to 0.
- Assert halt_req during EXEC of instr 0 of a 3-instr program → halt_req ignored, since it is not sampled in EXEC; instruction 1 still runs. Assert halt_req during WB of instr 1 → done after 2 retirements, pc=1.
- Drive load_en with new data mid-EXEC → memory unchanged, verified by re-running. In DONE, load_en=1 and start=1 together → word written, start ignored, state stays DONE.
- Drop rst_n for 1 cycle during EXEC of MUL → next cycle all outputs 0 and state IDLE, with no reg_we. A fresh start re-runs the same program correctly, since memory is retained.
